// File: rtl/emulib_rammodel_resp_timer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | emulib_rammodel_resp_timer_pkg                                           |
// | Shared ticket sizing and wrap-safe due comparison for the response timer |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package emulib_rammodel_resp_timer_pkg;

  localparam int TS_MAX_WIDTH = 64;

  // A ticket is the absolute release timestamp, so it is exactly as wide as the counter.
  function automatic int ticket_width(input int ts_width);
    return ts_width;
  endfunction

  // Due once (now - due) is non-negative in ts_width-bit two's complement.
  // This holds across wrap as long as the latency stays below 2^(ts_width-1).
  function automatic logic ts_is_due(input logic [TS_MAX_WIDTH-1:0] now,
                                     input logic [TS_MAX_WIDTH-1:0] due,
                                     input int                      ts_width);
    logic [TS_MAX_WIDTH-1:0] diff;
    logic [TS_MAX_WIDTH-1:0] msb;
    diff = now - due;
    msb  = diff >> (ts_width - 1);
    return ~msb[0];
  endfunction

endpackage : emulib_rammodel_resp_timer_pkg
`default_nettype wire

// File: rtl/emulib_rammodel_resp_timer_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | emulib_fifo                                                              |
// | Small ticket FIFO; push while full is dropped unless a pop frees a slot. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module emulib_fifo #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int FAST_READ = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_overflow
);
  import emulib_rammodel_resp_timer_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_do_pop   = i_pop && !w_empty;
  assign w_do_push  = i_push && (!w_full || w_do_pop);
  assign o_empty    = w_empty;
  assign o_overflow = i_push && !w_do_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= next_ptr(r_wptr);
      if (w_do_pop)  r_rptr <= next_ptr(r_rptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  generate
    if (FAST_READ != 0) begin : g_fast_read
      assign o_data = r_mem[r_rptr];
    end else begin : g_reg_read
      logic [WIDTH-1:0] r_dout;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_dout <= '0;
        else if (w_do_pop) r_dout <= r_mem[r_rptr];
      end
      assign o_data = r_dout;
    end
  endgenerate

endmodule : emulib_fifo
`default_nettype wire

// File: rtl/emulib_rammodel_resp_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | emulib_rammodel_resp_timer                                               |
// | Holds backend R/B responses until a fixed latency after their request.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module emulib_rammodel_resp_timer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int ID_WIDTH       = 4,
  parameter int MAX_R_INFLIGHT = 8,
  parameter int MAX_W_INFLIGHT = 8,
  parameter int R_LATENCY      = 10,
  parameter int W_LATENCY      = 6,
  parameter int TS_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic                  axi_wlast,

  input  logic                  be_rvalid,
  output logic                  be_rready,
  input  logic [DATA_WIDTH-1:0] be_rdata,
  input  logic [1:0]            be_rresp,
  input  logic [ID_WIDTH-1:0]   be_rid,
  input  logic                  be_rlast,

  input  logic                  be_bvalid,
  output logic                  be_bready,
  input  logic [1:0]            be_bresp,
  input  logic [ID_WIDTH-1:0]   be_bid,

  output logic                  axi_rvalid,
  input  logic                  axi_rready,
  output logic [DATA_WIDTH-1:0] axi_rdata,
  output logic [1:0]            axi_rresp,
  output logic [ID_WIDTH-1:0]   axi_rid,
  output logic                  axi_rlast,

  output logic                  axi_bvalid,
  input  logic                  axi_bready,
  output logic [1:0]            axi_bresp,
  output logic [ID_WIDTH-1:0]   axi_bid,

  // remu_trigger: sticky, cleared only by reset
  output logic                  ticket_overflow
);
  import emulib_rammodel_resp_timer_pkg::*;

  localparam int TICKET_W = ticket_width(TS_WIDTH);

  // Address width only keeps the parameter set aligned with the request side.
  generate
    if (ADDR_WIDTH < 1) begin : g_addr_width_unused
    end
  endgenerate

  logic [TS_WIDTH-1:0] r_now;
  logic                r_ticket_overflow;

  logic                w_ar_push;
  logic                w_w_push;
  logic [TICKET_W-1:0] w_r_push_ts;
  logic [TICKET_W-1:0] w_w_push_ts;
  logic [TICKET_W-1:0] w_r_head;
  logic [TICKET_W-1:0] w_w_head;
  logic                w_r_empty;
  logic                w_w_empty;
  logic                w_r_ovf;
  logic                w_w_ovf;
  logic                w_r_due;
  logic                w_b_due;
  logic                w_r_pop;
  logic                w_b_pop;

  assign w_ar_push   = axi_arvalid && axi_arready;
  assign w_w_push    = axi_wvalid && axi_wready && axi_wlast;
  assign w_r_push_ts = r_now + TICKET_W'(R_LATENCY);
  assign w_w_push_ts = r_now + TICKET_W'(W_LATENCY);

  emulib_fifo #(
    .WIDTH     (TICKET_W),
    .DEPTH     (MAX_R_INFLIGHT),
    .FAST_READ (1)
  ) u_r_tickets (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_ar_push),
    .i_data     (w_r_push_ts),
    .i_pop      (w_r_pop),
    .o_data     (w_r_head),
    .o_empty    (w_r_empty),
    .o_overflow (w_r_ovf)
  );

  emulib_fifo #(
    .WIDTH     (TICKET_W),
    .DEPTH     (MAX_W_INFLIGHT),
    .FAST_READ (1)
  ) u_w_tickets (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_w_push),
    .i_data     (w_w_push_ts),
    .i_pop      (w_b_pop),
    .o_data     (w_w_head),
    .o_empty    (w_w_empty),
    .o_overflow (w_w_ovf)
  );

  assign w_r_due = !w_r_empty &&
                   ts_is_due(TS_MAX_WIDTH'(r_now), TS_MAX_WIDTH'(w_r_head), TS_WIDTH);
  assign w_b_due = !w_w_empty &&
                   ts_is_due(TS_MAX_WIDTH'(r_now), TS_MAX_WIDTH'(w_w_head), TS_WIDTH);

  // Only the head ticket gates a burst; later beats follow with no extra delay.
  assign axi_rvalid = be_rvalid && w_r_due;
  assign be_rready  = axi_rready && w_r_due;
  assign axi_rdata  = be_rdata;
  assign axi_rresp  = be_rresp;
  assign axi_rid    = be_rid;
  assign axi_rlast  = be_rlast;
  assign w_r_pop    = be_rvalid && be_rready && be_rlast;

  assign axi_bvalid = be_bvalid && w_b_due;
  assign be_bready  = axi_bready && w_b_due;
  assign axi_bresp  = be_bresp;
  assign axi_bid    = be_bid;
  assign w_b_pop    = be_bvalid && be_bready;

  assign ticket_overflow = r_ticket_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_now             <= '0;
      r_ticket_overflow <= 1'b0;
    end else begin
      r_now             <= r_now + TS_WIDTH'(1);
      r_ticket_overflow <= r_ticket_overflow || w_r_ovf || w_w_ovf;
    end
  end

endmodule : emulib_rammodel_resp_timer
`default_nettype wire
